// File: rtl/frog_render.sv
// frog_render: tile-based frog game renderer.
// Two-stage colour pipeline keyed off the VGA timing inputs, plus a small
// READY/COOLDOWN move controller that only updates the frog at frame starts.
module frog_render #(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int START_COL       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [2:0] vga_b,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic [4:0] frog_col,
    output logic [3:0] frog_row,
    output logic       win_pulse
);

    localparam logic [4:0] START_COL_L = 5'(START_COL);
    localparam logic [3:0] START_ROW_L = 4'd14;
    localparam logic [3:0] CD_LOAD     = 4'(COOLDOWN_FRAMES);
    localparam logic [4:0] MAX_COL     = 5'd19;
    localparam logic [3:0] MAX_ROW     = 4'd14;

    // Pending-move direction encoding
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {READY, COOLDOWN} state_t;

    // ---------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------
    logic       von1_q, hs1_q, vs1_q;
    logic [4:0] tcol1_q;
    logic [3:0] trow1_q;
    logic [2:0] r_q, g_q, b_q;
    logic       hs2_q, vs2_q;
    logic [2:0] r_d, g_d, b_d;

    // Low pixel bits only select a position inside a tile; bit 9 of the
    // row is never set in the visible area.
    logic unused_pix;
    assign unused_pix = ^{pixel_x[4:0], pixel_y[9], pixel_y[4:0]};

    // Stage 1: capture tile coordinates, blanking and syncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            von1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            tcol1_q <= '0;
            trow1_q <= '0;
        end else begin
            von1_q  <= video_on;
            hs1_q   <= h_sync_in;
            vs1_q   <= v_sync_in;
            tcol1_q <= pixel_x[9:5];
            trow1_q <= pixel_y[8:5];
        end
    end

    // ---------------------------------------------------------------
    // Game state
    // ---------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_v_q, pend_v_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic [4:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       win_q, win_d;
    logic       up_q, down_q, left_q, right_q;

    // Colour lookup for the stage-1 tile against the live frog position.
    always_comb begin
        r_d = 3'd0;
        g_d = 3'd0;
        b_d = 3'd0;
        if (!von1_q) begin
            r_d = 3'd0;
        end else if (tcol1_q == col_q && trow1_q == row_q) begin
            g_d = 3'd7;
        end else if (trow1_q == 4'd0 || trow1_q == 4'd7 || trow1_q == 4'd14) begin
            g_d = 3'd4;
        end else if (trow1_q <= 4'd6) begin
            b_d = 3'd7;
        end else if (trow1_q <= 4'd13) begin
            r_d = 3'd2;
            g_d = 3'd2;
            b_d = 3'd2;
        end
    end

    // Stage 2: registered colour and aligned syncs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign vga_r      = r_q;
    assign vga_g      = g_q;
    assign vga_b      = b_q;
    assign h_sync_out = hs2_q;
    assign v_sync_out = vs2_q;

    // Edge detection: buttons against their own registered copies, frame
    // start against the stage-1 copy of v_sync.
    logic e_up, e_down, e_left, e_right, any_edge, frame_start;
    assign e_up        = btn_up    & ~up_q;
    assign e_down      = btn_down  & ~down_q;
    assign e_left      = btn_left  & ~left_q;
    assign e_right     = btn_right & ~right_q;
    assign any_edge    = e_up | e_down | e_left | e_right;
    assign frame_start = v_sync_in & ~vs1_q;

    // Button history registers for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            up_q    <= btn_up;
            down_q  <= btn_down;
            left_q  <= btn_left;
            right_q <= btn_right;
        end
    end

    // Next-state logic: home check first, then move apply, then cooldown
    // countdown, else latch a fresh press while idle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_v_d   = pend_v_q;
        pend_dir_d = pend_dir_q;
        col_d      = col_q;
        row_d      = row_q;
        win_d      = 1'b0;
        if (frame_start && row_q == 4'd0) begin
            col_d    = START_COL_L;
            row_d    = START_ROW_L;
            win_d    = 1'b1;
            pend_v_d = 1'b0;
            cnt_d    = '0;
            state_d  = READY;
        end else if (frame_start && state_q == READY && pend_v_q) begin
            unique case (pend_dir_q)
                DIR_UP:    if (row_q != 4'd0)  row_d = row_q - 4'd1;
                DIR_DOWN:  if (row_q != MAX_ROW) row_d = row_q + 4'd1;
                DIR_LEFT:  if (col_q != 5'd0)  col_d = col_q - 5'd1;
                DIR_RIGHT: if (col_q != MAX_COL) col_d = col_q + 5'd1;
                default:   ;
            endcase
            pend_v_d = 1'b0;
            cnt_d    = CD_LOAD;
            state_d  = COOLDOWN;
        end else if (frame_start && state_q == COOLDOWN) begin
            // Counter at 1 (or 0 defensively) reaches zero on this frame.
            if (cnt_q <= 4'd1) begin
                cnt_d   = '0;
                state_d = READY;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (state_q == READY && !pend_v_q && any_edge) begin
            pend_v_d = 1'b1;
            if (e_up)        pend_dir_d = DIR_UP;
            else if (e_down) pend_dir_d = DIR_DOWN;
            else if (e_left) pend_dir_d = DIR_LEFT;
            else             pend_dir_d = DIR_RIGHT;
        end
    end

    // Game state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= READY;
            cnt_q      <= '0;
            pend_v_q   <= 1'b0;
            pend_dir_q <= DIR_UP;
            col_q      <= START_COL_L;
            row_q      <= START_ROW_L;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_v_q   <= pend_v_d;
            pend_dir_q <= pend_dir_d;
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
        end
    end

    assign frog_col  = col_q;
    assign frog_row  = row_q;
    assign win_pulse = win_q;

endmodule

// File: tb/tb_frog_render.sv
// Directed bench for frog_render: colour table, sync alignment, move,
// cooldown, saturation, win and reset-abort sequences.
module tb_frog_render;

    logic       clk = 1'b0;
    logic       rst;
    logic       h_sync_in, v_sync_in, video_on;
    logic [9:0] pixel_x, pixel_y;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [2:0] vga_r, vga_g, vga_b;
    logic       h_sync_out, v_sync_out;
    logic [4:0] frog_col;
    logic [3:0] frog_row;
    logic       win_pulse;

    int n_cmp = 0;
    int n_err = 0;

    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

    frog_render dut (
        .clk(clk), .rst(rst),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
        .frog_col(frog_col), .frog_row(frog_row), .win_pulse(win_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       von;
        int         px;
        int         py;
        logic [8:0] rgb;
    } vec_t;

    vec_t vt[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input int d);
        btn_up    = (d == UP);
        btn_down  = (d == DOWN);
        btn_left  = (d == LEFT);
        btn_right = (d == RIGHT);
        tick();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        tick();
    endtask

    task automatic frame();
        v_sync_in = 1'b1;
        tick();
        v_sync_in = 1'b0;
        tick();
    endtask

    // One full move followed by the whole cooldown so the next press counts.
    task automatic move(input int d);
        press(d);
        frame();
        repeat (8) frame();
    endtask

    initial begin
        logic [9:0] hs_pat, vs_pat;

        vt[0]  = '{1'b1, 293, 451, {3'd0, 3'd7, 3'd0}};  // frog tile (9,14)
        vt[1]  = '{1'b0, 293, 451, {3'd0, 3'd0, 3'd0}};  // blanked
        vt[2]  = '{1'b1,   0,   0, {3'd0, 3'd4, 3'd0}};  // grass row 0
        vt[3]  = '{1'b1, 100,  96, {3'd0, 3'd0, 3'd7}};  // water row 3
        vt[4]  = '{1'b1,  50, 351, {3'd2, 3'd2, 3'd2}};  // road row 10
        vt[5]  = '{1'b1, 639, 224, {3'd0, 3'd4, 3'd0}};  // grass row 7
        vt[6]  = '{1'b1, 287, 460, {3'd0, 3'd4, 3'd0}};  // col 8 row 14
        vt[7]  = '{1'b1, 319,  32, {3'd0, 3'd0, 3'd7}};  // water row 1
        vt[8]  = '{1'b1,   0, 447, {3'd2, 3'd2, 3'd2}};  // road row 13
        vt[9]  = '{1'b1, 639, 479, {3'd0, 3'd4, 3'd0}};  // last pixel
        vt[10] = '{1'b1, 320, 448, {3'd0, 3'd4, 3'd0}};  // col 10 row 14
        vt[11] = '{1'b1, 293, 416, {3'd2, 3'd2, 3'd2}};  // col 9 row 13

        rst = 1; h_sync_in = 0; v_sync_in = 0; video_on = 1;
        pixel_x = 10'd293; pixel_y = 10'd451;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_vga", {7'd0, vga_r, vga_g, vga_b}, 16'd0);
        chk("rst_col", {11'd0, frog_col}, 16'd9);
        chk("rst_row", {12'd0, frog_row}, 16'd14);
        chk("rst_win", {15'd0, win_pulse}, 16'd0);
        rst = 0;
        video_on = 0;
        tick();

        // Colour table: input held one clock, then changed, result 2 clocks on
        for (int i = 0; i < 12; i++) begin
            video_on = vt[i].von;
            pixel_x  = 10'(vt[i].px);
            pixel_y  = 10'(vt[i].py);
            tick();
            video_on = 1'b0;
            tick();
            chk($sformatf("pix%0d", i), {7'd0, vga_r, vga_g, vga_b}, {7'd0, vt[i].rgb});
        end

        // Sync alignment (2 clocks)
        hs_pat = 10'b1001101101;
        vs_pat = 10'b0010010110;
        for (int i = 0; i < 10; i++) begin
            h_sync_in = hs_pat[i];
            v_sync_in = vs_pat[i];
            tick();
            if (i >= 1) begin
                chk($sformatf("hs%0d", i), {15'd0, h_sync_out}, {15'd0, hs_pat[i-1]});
                chk($sformatf("vs%0d", i), {15'd0, v_sync_out}, {15'd0, vs_pat[i-1]});
            end
        end
        h_sync_in = 0; v_sync_in = 0;
        tick(); tick();
        chk("sync_row", {12'd0, frog_row}, 16'd14);

        // Bottom edge: blocked move still starts cooldown
        press(DOWN); frame();
        chk("sat_down_row", {12'd0, frog_row}, 16'd14);
        press(UP); frame();
        chk("sat_cd_row", {12'd0, frog_row}, 16'd14);
        repeat (7) frame();

        // Move up, then presses during 8 cooldown frames are discarded
        press(UP); frame();
        chk("up1_row", {12'd0, frog_row}, 16'd13);
        for (int k = 1; k <= 8; k++) begin
            press(UP); frame();
            chk($sformatf("cd%0d_row", k), {12'd0, frog_row}, 16'd13);
        end
        press(UP); frame();
        chk("up2_row", {12'd0, frog_row}, 16'd12);
        chk("up2_col", {11'd0, frog_col}, 16'd9);
        repeat (8) frame();

        // Same-clock up+left: up wins
        btn_up = 1; btn_left = 1;
        tick();
        btn_up = 0; btn_left = 0;
        tick();
        frame();
        chk("prio_row", {12'd0, frog_row}, 16'd11);
        chk("prio_col", {11'd0, frog_col}, 16'd9);
        repeat (8) frame();

        // Right edge at (19,5)
        repeat (6) move(UP);
        repeat (10) move(RIGHT);
        chk("edge_col", {11'd0, frog_col}, 16'd19);
        chk("edge_row", {12'd0, frog_row}, 16'd5);
        press(RIGHT); frame();
        chk("sat_right_col", {11'd0, frog_col}, 16'd19);
        press(UP); frame();
        chk("sat_right_cd", {12'd0, frog_row}, 16'd5);
        repeat (7) frame();

        // Reach row 0, then home on next frame start
        repeat (4) move(UP);
        press(UP); frame();
        chk("row0", {12'd0, frog_row}, 16'd0);
        chk("row0_win", {15'd0, win_pulse}, 16'd0);
        v_sync_in = 1'b1;
        tick();
        chk("win_hi", {15'd0, win_pulse}, 16'd1);
        chk("win_col", {11'd0, frog_col}, 16'd9);
        chk("win_row", {12'd0, frog_row}, 16'd14);
        v_sync_in = 1'b0;
        tick();
        chk("win_lo1", {15'd0, win_pulse}, 16'd0);
        tick();
        chk("win_lo2", {15'd0, win_pulse}, 16'd0);

        // Walk to (3,4) with one down step, last move left in cooldown
        repeat (10) move(UP);
        move(DOWN);
        chk("down_row", {12'd0, frog_row}, 16'd5);
        move(UP);
        repeat (5) move(LEFT);
        press(LEFT); frame();
        chk("pre_col", {11'd0, frog_col}, 16'd3);
        chk("pre_row", {12'd0, frog_row}, 16'd4);
        video_on = 1; pixel_x = 10'd0; pixel_y = 10'd0; h_sync_in = 1;
        tick(); tick();
        chk("pre_vga", {7'd0, vga_r, vga_g, vga_b}, {7'd0, 3'd0, 3'd4, 3'd0});

        // Asynchronous reset mid-cooldown
        #2 rst = 1;
        #1;
        chk("arst_vga", {7'd0, vga_r, vga_g, vga_b}, 16'd0);
        chk("arst_hs", {15'd0, h_sync_out}, 16'd0);
        chk("arst_col", {11'd0, frog_col}, 16'd9);
        chk("arst_row", {12'd0, frog_row}, 16'd14);
        tick(); tick();
        rst = 0; video_on = 0; h_sync_in = 0;
        tick();
        frame();
        chk("post_nopress", {12'd0, frog_row}, 16'd14);
        press(UP); frame();
        chk("post_move", {12'd0, frog_row}, 16'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frog_render.md
FROG_RENDER -- requirements
Module: frog_render

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 8: frames after a move during which new presses are discarded; legal range 1..15.
REQ-002 Parameter START_COL, default 9: frog tile column after reset or a win; legal range 0..19.
REQ-003 clk  input  1  pixel clock; the only clock.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 h_sync_in  input  1  horizontal sync from the VGA timing stage; active-high.
REQ-006 v_sync_in  input  1  vertical sync from the VGA timing stage; active-high.
REQ-007 video_on  input  1  high inside the 640x480 visible area.
REQ-008 pixel_x  input  10  visible pixel column, 0..639.
REQ-009 pixel_y  input  10  visible pixel row, 0..479.
REQ-010 btn_up, btn_down, btn_left, btn_right  input  1 each  level inputs, already debounced and synchronised.
REQ-011 vga_r, vga_g, vga_b  output  3 each  pixel colour.
REQ-012 h_sync_out, v_sync_out  output  1 each  syncs delayed to align with the colour outputs.
REQ-013 frog_col  output  5  current frog tile column, 0..19.
REQ-014 frog_row  output  4  current frog tile row, 0..14.
REQ-015 win_pulse  output  1  single-cycle pulse when the frog is sent home from row 0.

Function
REQ-016 The screen is a grid of 32x32-pixel tiles: tile column = pixel_x[9:5], tile row = pixel_y[8:5].
REQ-017 Pipeline latency is exactly 2 clocks from the inputs to vga_*; h_sync_out and v_sync_out shall be h_sync_in and v_sync_in delayed by the same 2 clocks.
REQ-018 Colour selection, in priority order:
- video_on low (as delayed) -> 0/0/0.
- Tile equals (frog_col, frog_row) -> frog colour 0/7/0.
- Row 0, 7 or 14 (grass) -> 0/4/0.
- Rows 1-6 (water) -> 0/0/7.
- Rows 8-13 (road) -> 2/2/2.
REQ-019 Button rising edges are detected against a 1-clock registered copy of each button; a held button produces exactly one edge.
REQ-020 A frame start is the rising edge of v_sync_in, detected on the registered copy.
REQ-021 The FSM has two states, READY and COOLDOWN.
REQ-022 In READY, the first button edge is latched as the pending move. Edges on several buttons in the same clock resolve by priority up > down > left > right. Later edges are ignored while a move is pending.
REQ-023 At a frame start in READY with a move pending:
- Apply the move: up decrements frog_row; down increments it; left decrements frog_col; right increments it.
- Clear the pending move, load the cooldown counter with COOLDOWN_FRAMES, and enter COOLDOWN.
REQ-024 Moves saturate at the grid edges: row 0..14, column 0..19. A blocked move still consumes the press and starts the cooldown.
REQ-025 In COOLDOWN, button edges are discarded. Each frame start decrements the counter; when it reaches 0, the FSM returns to READY at that same frame start.
REQ-026 At a frame start with frog_row = 0 (checked before any pending move is applied):
- Set the frog to (START_COL, 14) and pulse win_pulse high for exactly one clock.
- Discard the pending move and enter READY with the counter cleared.
REQ-027 frog_col and frog_row change only on a frame-start clock, so the frog position never changes within a displayed frame.

Reset
REQ-028 While rst is high, and immediately on its assertion:
- vga_*, h_sync_out, v_sync_out, win_pulse and all pipeline registers are 0.
- The frog is at (START_COL, 14); pending move, edge registers and cooldown counter are cleared; the FSM is in READY.
REQ-029 Reset asserted mid-frame or mid-cooldown aborts all activity. After release, the first move requires a fresh button edge and then a frame start.

Verification
REQ-030 Reset, then a pixel at tile (9,14) with video_on=1 -> vga = 0/7/0 exactly 2 clocks later; h_sync_out equals h_sync_in delayed 2 clocks.
REQ-031 Press btn_up once, then a frame start -> frog_row 14->13 on that clock. A second btn_up press within the next 8 frame starts -> no move. A press after the 8th frame start -> moves at the next frame start.
REQ-032 btn_left and btn_up rising in the same clock, then a frame start -> frog_row decrements and frog_col is unchanged.
REQ-033 Frog at (19,5), press btn_right, then a frame start -> frog_col stays 19 and the FSM enters COOLDOWN.
REQ-034 Drive the frog to row 0, then a frame start -> frog returns to (9,14) and win_pulse is high for exactly 1 clock.
REQ-035 Assert rst during COOLDOWN with the frog at (3,4) -> outputs 0 and the frog at (9,14) immediately; after release, one press plus one frame start moves the frog.
